stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//  Run/pause/lap/clear controller sequencing the 4-digit BCD multi-decade counter as a stopwatch.
//  Conditions three push-buttons and drives counter enable and reset.
//  Drives the digits shown by the seven-segment driver, either live or a frozen lap value.
//  Sits between board buttons and the counter/display datapath in the top level, on the system clock.
// PARAMETERS
//  DEBOUNCE_CYCLES  1_000_000  stable-level cycles required before a button change is accepted (10 ms @ 100 MHz)
//  DB_W             20         width of debounce counter; must hold DEBOUNCE_CYCLES-1
//  LIMIT_BCD        16'h9999   BCD count at which a running stopwatch auto-stops
// PORTS
//  clk            in   1   system clock
//  reset_n        in   1   synchronous, active-low reset
//  btn_startstop  in   1   raw button, active-high, asynchronous to clk
//  btn_lap        in   1   raw button, active-high, asynchronous to clk
//  btn_clear      in   1   raw button, active-high, asynchronous to clk
//  count_in       in   16  counter digits {d3,d2,d1,d0}, BCD, d0 = LSD
//  cnt_enable     out  1   counter enable
//  cnt_rst        out  1   counter reset, active-high, level
//  disp_digits    out  16  digits to sseg driver
//  lap_active     out  1   1 = disp_digits frozen at lap value
//  state_o        out  2   current state code: IDLE=0, RUN=1, PAUSE=2, DONE=3; CLEAR reports 0
// BEHAVIOUR
//  Clock and reset
//   - One clock; reset is synchronous and active-low (reset_n sampled on rising clk).
//   - Reset values: state IDLE, cnt_enable=0, cnt_rst=0, lap_active=0, lap_reg=0, button pipelines cleared.
//  Button conditioning
//   - Each button: 2-FF synchronizer, then debounce (see CONFIGURATION), then rising-edge detect.
//   - Output is a 1-cycle event pulse ss_ev, lap_ev or clr_ev.
//   - Event latency from raw edge (debounce off): 3 cycles.
//  Event priority
//   - Same-cycle events resolve clr_ev > ss_ev > lap_ev.
//   - Lower-priority events in that cycle are dropped.
//  State machine (registered, 5 states)
//   - IDLE:  ss_ev -> RUN; clr_ev -> CLEAR.
//   - RUN:   ss_ev -> PAUSE; lap_ev toggles lap_active; clr_ev ignored.
//   - RUN:   count_in == LIMIT_BCD -> DONE. This beats ss_ev and lap_ev in the same cycle.
//   - PAUSE: ss_ev -> RUN; clr_ev -> CLEAR; lap_ev clears lap_active.
//   - DONE:  clr_ev -> CLEAR; ss_ev and lap_ev ignored.
//   - CLEAR: hold cnt_rst=1 until count_in == 16'h0000 is sampled, then -> IDLE.
//     This is the handshake with the slow-clocked counter. Events arriving in CLEAR are dropped.
//  Outputs
//   - cnt_enable is registered and equals (next_state == RUN). It falls on the same edge that enters PAUSE or DONE.
//   - cnt_rst is registered and equals (next_state == CLEAR).
//   - Entering CLEAR also clears lap_active and lap_reg to 0.
//   - On a lap_active 0->1 toggle, lap_reg captures count_in in the same edge.
//   - disp_digits = lap_active ? lap_reg : count_in. This mux is combinational.
//  Boundary conditions
//   - count_in is never range-checked; non-BCD input is passed through.
//   - The LIMIT_BCD compare is exact equality.
//   - reset_n low mid-CLEAR drops cnt_rst on the next edge; the counter is not guaranteed cleared.
// CONFIGURATION
//  Macro STOPWATCH_DEBOUNCE_EN
//   - Defined: a per-button counter restarts on every synchronized level change.
//     The debounced level updates only after DEBOUNCE_CYCLES stable cycles. Event latency is DEBOUNCE_CYCLES+3.
//   - Undefined: no debounce counter; the synchronized level feeds edge detect directly. DB_W is unused.
// STRUCTURE
//  Package stopwatch_pkg
//   - state_t enum: IDLE, RUN, PAUSE, DONE, CLEAR.
//   - Localparams: BCD_ZERO = 16'h0000, DIGITS = 4.
//  Sub-module btn_conditioner
//   - Contents: synchronizer + optional debounce + edge detect.
//   - Instantiated 3 times. Parameter DEBOUNCE_CYCLES is passed through.
//   - Ports: clk, reset_n, btn_raw, level, rise.
// TESTING
//  (run with STOPWATCH_DEBOUNCE_EN undefined; one test with it defined and DEBOUNCE_CYCLES=8)
//  1. Reset with reset_n=0 for 2 cycles -> state_o=0, cnt_enable=0, cnt_rst=0, disp_digits=count_in.
//  2. Pulse btn_startstop in IDLE -> cnt_enable=1, state_o=1, 3 cycles later.
//     Pulse it again -> cnt_enable=0, state_o=2.
//  3. RUN with count_in=16'h0123, pulse btn_lap -> lap_active=1, disp_digits holds 16'h0123 while count_in changes.
//     Pulse btn_lap again -> disp_digits follows count_in.
//  4. RUN, drive count_in=16'h9999 -> next edge state_o=3, cnt_enable=0. btn_startstop in DONE -> no change.
//  5. PAUSE, pulse btn_clear -> cnt_rst=1 held while count_in=16'h0042.
//     Drive count_in=0 -> next edge cnt_rst=0, state_o=0, lap_active=0.
//  6. btn_clear and btn_startstop rise together in PAUSE -> CLEAR entered, RUN not entered.
//  7. Debounce on: glitch of 5 cycles -> no event. Hold 8+ cycles -> exactly one event.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller.
//   state_t    : controller state encoding (CLEAR sits above the 2-bit
//                code space and is reported as 0 on state_o)
//   BCD_ZERO   : all-zero counter value that completes the clear handshake
//   DIGITS     : number of BCD digits on count_in / disp_digits
//   state_code : maps a state to the externally reported 2-bit code
package stopwatch_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    PAUSE = 3'd2,
    DONE  = 3'd3,
    CLEAR = 3'd4
  } state_t;

  localparam logic [15:0] BCD_ZERO = 16'h0000;
  localparam int          DIGITS   = 4;

  function automatic logic [1:0] state_code(input state_t s);
    return (s == CLEAR) ? 2'd0 : 2'(s);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_conditioner.sv
// btn_conditioner: conditions one raw asynchronous push-button.
//   2-FF synchronizer -> optional debounce -> rising-edge detect.
//   Macro STOPWATCH_DEBOUNCE_EN enables the debounce counter; without it
//   the synchronized level drives the edge detector directly.
// Ports:
//   clk      in  system clock
//   reset_n  in  synchronous active-low reset
//   btn_raw  in  raw button, active-high, asynchronous
//   level    out conditioned button level
//   rise     out 1-cycle pulse on a 0->1 change of level
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int DB_W            = 20
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    prev_d  = level;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

`ifdef STOPWATCH_DEBOUNCE_EN
  // Count only while the synchronized level disagrees with the accepted
  // level; any return to agreement restarts the count, so a bounce of
  // either polarity is rejected.
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic            db_q,  db_d;

  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (sync2_q != db_q) begin
      if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) db_d = sync2_q;
      else                                      cnt_d = cnt_q + DB_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
      db_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end

  assign level = db_q;
`else
  logic [DB_W-1:0] unused_db;
  assign unused_db = DB_W'(DEBOUNCE_CYCLES);
  assign level     = sync2_q;
`endif

  assign rise = level & ~prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/lap/clear sequencer for a 4-digit BCD counter.
//   Conditions three buttons, drives counter enable/reset, and selects
//   live or lap-frozen digits for the seven-segment driver.
//   Optional macro STOPWATCH_DEBOUNCE_EN turns on button debouncing.
// Ports:
//   clk, reset_n      system clock, synchronous active-low reset
//   btn_startstop     raw start/stop button
//   btn_lap           raw lap button
//   btn_clear         raw clear button
//   count_in          counter digits {d3,d2,d1,d0}
//   cnt_enable        counter enable (registered)
//   cnt_rst           counter reset, active-high level (registered)
//   disp_digits       digits to display (combinational mux)
//   lap_active        display frozen at lap value
//   state_o           IDLE=0 RUN=1 PAUSE=2 DONE=3 (CLEAR reads as 0)
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = 1_000_000,
  parameter int          DB_W            = 20,
  parameter logic [15:0] LIMIT_BCD       = 16'h9999
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  btn_startstop,
  input  logic                  btn_lap,
  input  logic                  btn_clear,
  input  logic [DIGITS*4-1:0]   count_in,
  output logic                  cnt_enable,
  output logic                  cnt_rst,
  output logic [DIGITS*4-1:0]   disp_digits,
  output logic                  lap_active,
  output logic [1:0]            state_o
);

  logic [2:0] unused_lvl;
  logic       ss_ev, lap_ev, clr_ev;

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_ss (
    .clk(clk), .reset_n(reset_n), .btn_raw(btn_startstop),
    .level(unused_lvl[0]), .rise(ss_ev)
  );
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_lap (
    .clk(clk), .reset_n(reset_n), .btn_raw(btn_lap),
    .level(unused_lvl[1]), .rise(lap_ev)
  );
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_clr (
    .clk(clk), .reset_n(reset_n), .btn_raw(btn_clear),
    .level(unused_lvl[2]), .rise(clr_ev)
  );

  // Same-cycle events: clear beats start/stop beats lap; losers are dropped.
  logic clr_p, ss_p, lap_p, at_limit;
  assign clr_p    = clr_ev;
  assign ss_p     = ss_ev  & ~clr_ev;
  assign lap_p    = lap_ev & ~ss_ev & ~clr_ev;
  assign at_limit = (count_in == LIMIT_BCD);

  state_t                state_q, state_d;
  logic                  cnt_enable_q, cnt_enable_d;
  logic                  cnt_rst_q,    cnt_rst_d;
  logic                  lap_active_q, lap_active_d;
  logic [DIGITS*4-1:0]   lap_reg_q,    lap_reg_d;

  // State register (plus registered outputs)
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_enable_q <= 1'b0;
      cnt_rst_q    <= 1'b0;
      lap_active_q <= 1'b0;
      lap_reg_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_enable_q <= cnt_enable_d;
      cnt_rst_q    <= cnt_rst_d;
      lap_active_q <= lap_active_d;
      lap_reg_q    <= lap_reg_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (clr_p) state_d = CLEAR;
             else if (ss_p) state_d = RUN;
      // Reaching the limit wins over any button in the same cycle.
      RUN:   if (at_limit) state_d = DONE;
             else if (ss_p) state_d = PAUSE;
      PAUSE: if (clr_p) state_d = CLEAR;
             else if (ss_p) state_d = RUN;
      DONE:  if (clr_p) state_d = CLEAR;
      // Hold the counter in reset until it reports zero; the counter may
      // run on a slower clock so one cycle of cnt_rst is not enough.
      CLEAR: if (count_in == BCD_ZERO) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    cnt_enable_d = (state_d == RUN);
    cnt_rst_d    = (state_d == CLEAR);
    lap_active_d = lap_active_q;
    lap_reg_d    = lap_reg_q;
    if (state_d == CLEAR && state_q != CLEAR) begin
      lap_active_d = 1'b0;
      lap_reg_d    = '0;
    end else if (state_q == RUN && !at_limit && lap_p) begin
      lap_active_d = ~lap_active_q;
      if (!lap_active_q) lap_reg_d = count_in;
    end else if (state_q == PAUSE && lap_p) begin
      lap_active_d = 1'b0;
    end
  end

  assign cnt_enable  = cnt_enable_q;
  assign cnt_rst     = cnt_rst_q;
  assign lap_active  = lap_active_q;
  assign disp_digits = lap_active_q ? lap_reg_q : count_in;
  assign state_o     = state_code(state_q);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed testbench for stopwatch_ctrl. Button latency follows the
// STOPWATCH_DEBOUNCE_EN build setting (DEBOUNCE_CYCLES=8 in the bench).
module tb_stopwatch_ctrl;

`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int LAT = 8 + 3;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        btn_ss, btn_lap, btn_clr;
  logic [15:0] count_in;
  logic        cnt_enable, cnt_rst, lap_active;
  logic [15:0] disp_digits;
  logic [1:0]  state_o;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(8), .DB_W(4), .LIMIT_BCD(16'h9999)) dut (
    .clk(clk), .reset_n(reset_n),
    .btn_startstop(btn_ss), .btn_lap(btn_lap), .btn_clear(btn_clr),
    .count_in(count_in),
    .cnt_enable(cnt_enable), .cnt_rst(cnt_rst),
    .disp_digits(disp_digits), .lap_active(lap_active), .state_o(state_o)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raise the selected buttons and wait until their event has been acted on.
  task automatic press(input logic ss, input logic lap, input logic clr);
    btn_ss = ss; btn_lap = lap; btn_clr = clr;
    tick(LAT);
  endtask

  task automatic release_all();
    btn_ss = 1'b0; btn_lap = 1'b0; btn_clr = 1'b0;
    tick(LAT + 1);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; count_in = 16'h1234;
    btn_ss = 1'b0; btn_lap = 1'b0; btn_clr = 1'b0;
    tick(2);
    total++; if (state_o !== 2'd0) $display("FAIL reset_state got %0d want 0", state_o); else passed++;
    total++; if (cnt_enable !== 1'b0) $display("FAIL reset_en got %b want 0", cnt_enable); else passed++;
    total++; if (cnt_rst !== 1'b0) $display("FAIL reset_rst got %b want 0", cnt_rst); else passed++;
    total++; if (lap_active !== 1'b0) $display("FAIL reset_lap got %b want 0", lap_active); else passed++;
    total++; if (disp_digits !== 16'h1234) $display("FAIL reset_disp got %h want 1234", disp_digits); else passed++;
    reset_n = 1'b1; count_in = 16'h0000;
    tick(1);
  endtask

  task automatic test_run_pause();
    btn_ss = 1'b1;
    tick(LAT - 1);
    total++; if (state_o !== 2'd0) $display("FAIL run_early got %0d want 0", state_o); else passed++;
    tick(1);
    total++; if (state_o !== 2'd1) $display("FAIL run_state got %0d want 1", state_o); else passed++;
    total++; if (cnt_enable !== 1'b1) $display("FAIL run_en got %b want 1", cnt_enable); else passed++;
    release_all();
    total++; if (state_o !== 2'd1) $display("FAIL run_hold got %0d want 1", state_o); else passed++;
    press(1, 0, 0);
    total++; if (state_o !== 2'd2) $display("FAIL pause_state got %0d want 2", state_o); else passed++;
    total++; if (cnt_enable !== 1'b0) $display("FAIL pause_en got %b want 0", cnt_enable); else passed++;
    release_all();
  endtask

  task automatic test_lap();
    press(1, 0, 0); release_all();  // PAUSE -> RUN
    total++; if (state_o !== 2'd1) $display("FAIL lap_run got %0d want 1", state_o); else passed++;
    count_in = 16'h0123;
    press(0, 1, 0);
    total++; if (lap_active !== 1'b1) $display("FAIL lap_on got %b want 1", lap_active); else passed++;
    count_in = 16'h0456; tick(1);
    total++; if (disp_digits !== 16'h0123) $display("FAIL lap_frozen got %h want 0123", disp_digits); else passed++;
    release_all();
    press(0, 1, 0);
    total++; if (lap_active !== 1'b0) $display("FAIL lap_off got %b want 0", lap_active); else passed++;
    count_in = 16'h0789; tick(1);
    total++; if (disp_digits !== 16'h0789) $display("FAIL lap_live got %h want 0789", disp_digits); else passed++;
    release_all();
    press(0, 1, 0); release_all();  // freeze 0789
    press(1, 0, 0); release_all();  // RUN -> PAUSE keeps the lap
    count_in = 16'h0800; tick(1);
    total++; if (disp_digits !== 16'h0789) $display("FAIL lap_pause_keep got %h want 0789", disp_digits); else passed++;
    press(0, 1, 0);
    total++; if (lap_active !== 1'b0) $display("FAIL lap_pause_clr got %b want 0", lap_active); else passed++;
    total++; if (disp_digits !== 16'h0800) $display("FAIL lap_pause_disp got %h want 0800", disp_digits); else passed++;
    release_all();
  endtask

  task automatic test_limit();
    press(1, 0, 0); release_all();  // PAUSE -> RUN
    press(0, 0, 1);                 // clear ignored while running
    total++; if (state_o !== 2'd1) $display("FAIL run_clr_state got %0d want 1", state_o); else passed++;
    total++; if (cnt_rst !== 1'b0) $display("FAIL run_clr_rst got %b want 0", cnt_rst); else passed++;
    release_all();
    count_in = 16'h9998; tick(1);
    total++; if (state_o !== 2'd1) $display("FAIL limit_9998 got %0d want 1", state_o); else passed++;
    count_in = 16'h9999; tick(1);
    total++; if (state_o !== 2'd3) $display("FAIL limit_state got %0d want 3", state_o); else passed++;
    total++; if (cnt_enable !== 1'b0) $display("FAIL limit_en got %b want 0", cnt_enable); else passed++;
    press(1, 0, 0);
    total++; if (state_o !== 2'd3) $display("FAIL done_ss got %0d want 3", state_o); else passed++;
    total++; if (cnt_enable !== 1'b0) $display("FAIL done_en got %b want 0", cnt_enable); else passed++;
    release_all();
  endtask

  task automatic test_clear();
    count_in = 16'h0042;
    press(0, 0, 1);                 // DONE -> CLEAR
    total++; if (cnt_rst !== 1'b1) $display("FAIL clr_rst got %b want 1", cnt_rst); else passed++;
    total++; if (state_o !== 2'd0) $display("FAIL clr_state got %0d want 0", state_o); else passed++;
    release_all();
    press(1, 0, 0);                 // dropped while clearing
    release_all();
    total++; if (cnt_rst !== 1'b1) $display("FAIL clr_hold got %b want 1", cnt_rst); else passed++;
    count_in = 16'h0000; tick(1);
    total++; if (cnt_rst !== 1'b0) $display("FAIL clr_done_rst got %b want 0", cnt_rst); else passed++;
    tick(2);
    total++; if (cnt_enable !== 1'b0) $display("FAIL clr_drop_ss got %b want 0", cnt_enable); else passed++;
    // clear from PAUSE with a lap frozen
    press(1, 0, 0); release_all();
    count_in = 16'h0042;
    press(0, 1, 0); release_all();
    count_in = 16'h0050;
    press(1, 0, 0); release_all();
    total++; if (lap_active !== 1'b1) $display("FAIL clr_pre_lap got %b want 1", lap_active); else passed++;
    press(0, 0, 1);
    total++; if (cnt_rst !== 1'b1) $display("FAIL clr_pause_rst got %b want 1", cnt_rst); else passed++;
    total++; if (lap_active !== 1'b0) $display("FAIL clr_lap got %b want 0", lap_active); else passed++;
    total++; if (disp_digits !== 16'h0050) $display("FAIL clr_disp got %h want 0050", disp_digits); else passed++;
    release_all();
    count_in = 16'h0000; tick(1);
    total++; if (cnt_rst !== 1'b0) $display("FAIL clr_exit got %b want 0", cnt_rst); else passed++;
  endtask

  task automatic test_priority();
    press(1, 0, 0); release_all();  // IDLE -> RUN
    press(1, 0, 0); release_all();  // RUN -> PAUSE
    count_in = 16'h0042;
    press(1, 0, 1);
    total++; if (cnt_rst !== 1'b1) $display("FAIL prio_rst got %b want 1", cnt_rst); else passed++;
    total++; if (cnt_enable !== 1'b0) $display("FAIL prio_en got %b want 0", cnt_enable); else passed++;
    total++; if (state_o !== 2'd0) $display("FAIL prio_state got %0d want 0", state_o); else passed++;
    release_all();
    count_in = 16'h0000; tick(1);
    total++; if (cnt_rst !== 1'b0) $display("FAIL prio_exit got %b want 0", cnt_rst); else passed++;
  endtask

  task automatic test_reset_mid_clear();
    count_in = 16'h0042;
    press(0, 0, 1);
    total++; if (cnt_rst !== 1'b1) $display("FAIL midclr_rst got %b want 1", cnt_rst); else passed++;
    btn_clr = 1'b0; reset_n = 1'b0;
    tick(1);
    total++; if (cnt_rst !== 1'b0) $display("FAIL midclr_drop got %b want 0", cnt_rst); else passed++;
    reset_n = 1'b1;
    tick(LAT + 1);
    total++; if (cnt_rst !== 1'b0) $display("FAIL midclr_after got %b want 0", cnt_rst); else passed++;
    total++; if (state_o !== 2'd0) $display("FAIL midclr_state got %0d want 0", state_o); else passed++;
    count_in = 16'h0000;
  endtask

  task automatic test_hold_long();
`ifdef STOPWATCH_DEBOUNCE_EN
    btn_ss = 1'b1; tick(5);
    btn_ss = 1'b0; tick(20);
    total++; if (state_o !== 2'd0) $display("FAIL glitch got %0d want 0", state_o); else passed++;
`endif
    btn_ss = 1'b1; tick(30);
    total++; if (state_o !== 2'd1) $display("FAIL hold_one got %0d want 1", state_o); else passed++;
    release_all();
    total++; if (state_o !== 2'd1) $display("FAIL hold_release got %0d want 1", state_o); else passed++;
  endtask

  initial begin
    test_reset();
    test_run_pause();
    test_lap();
    test_limit();
    test_clear();
    test_priority();
    test_reset_mid_clear();
    test_hold_long();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
